// File: rtl/openddr_pkg.sv
// Shared types and constants for the OpenDDR RTL / SystemC path switch controller.
// The path_up helper picks the readiness signal that belongs to a given mux select.
package openddr_pkg;

  typedef enum logic [1:0] {
    PSW_INIT   = 2'd0,
    PSW_ACTIVE = 2'd1,
    PSW_DRAIN  = 2'd2,
    PSW_SWITCH = 2'd3
  } psw_state_t;

  localparam logic PATH_RTL = 1'b0;
  localparam logic PATH_SC  = 1'b1;

  function automatic logic path_up(input logic sel, input logic rtl_up, input logic sc_up);
    return (sel == PATH_SC) ? sc_up : rtl_up;
  endfunction

endpackage

// File: rtl/openddr_ost_counter.sv
// Saturating up/down counter of outstanding transactions for one AXI direction.
// err is sticky and flags any attempted underflow or overflow.
module openddr_ost_counter
  import openddr_pkg::*;
#(
  parameter int MAX_OST = 16,
  parameter int OST_W   = $clog2(MAX_OST + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             inc,
  input  logic             dec,
  output logic [OST_W-1:0] count,
  output logic             err
);

  logic [OST_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case ({inc, dec})
      2'b10: begin
        if (count_q == OST_W'(MAX_OST)) err_d = 1'b1;
        else                            count_d = count_q + OST_W'(1);
      end
      2'b01: begin
        if (count_q == '0) err_d = 1'b1;
        else               count_d = count_q - OST_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/openddr_path_switch_ctrl.sv
// Hands the controller-side AXI port between the RTL controller and the SystemC model:
// closes the AW/AR gates, drains in-flight traffic, flips the mux, settles, then waits for path-up.
module openddr_path_switch_ctrl
  import openddr_pkg::*;
#(
  parameter int MAX_OST       = 16,
  parameter int OST_W         = $clog2(MAX_OST + 1),
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             mode_select,
  input  logic             aw_hs,
  input  logic             ar_hs,
  input  logic             b_hs,
  input  logic             r_last_hs,
  input  logic             rtl_path_up,
  input  logic             sc_path_up,
  output logic             path_sel,
  output logic             aw_gate,
  output logic             ar_gate,
  output logic             rtl_ready,
  output logic             systemc_ready,
  output logic [OST_W-1:0] wr_ost,
  output logic [OST_W-1:0] rd_ost,
  output logic             ost_err,
  output logic             drain_timeout
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  psw_state_t       state_q, state_d;
  logic             path_sel_q, path_sel_d;
  logic             drain_target_q, drain_target_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             wr_err, rd_err;
  logic             active_up, pure_switch;

  // Counters track handshakes in every state, including the cycle a mode change is sampled.
  openddr_ost_counter #(.MAX_OST(MAX_OST), .OST_W(OST_W)) u_wr_ost (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (aw_hs),
    .dec     (b_hs),
    .count   (wr_ost),
    .err     (wr_err)
  );

  openddr_ost_counter #(.MAX_OST(MAX_OST), .OST_W(OST_W)) u_rd_ost (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (ar_hs),
    .dec     (r_last_hs),
    .count   (rd_ost),
    .err     (rd_err)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= PSW_INIT;
      path_sel_q      <= PATH_RTL;
      drain_target_q  <= PATH_RTL;
      settle_q        <= '0;
      tmo_q           <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      path_sel_q      <= path_sel_d;
      drain_target_q  <= drain_target_d;
      settle_q        <= settle_d;
      tmo_q           <= tmo_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign active_up   = path_up(path_sel_q, rtl_path_up, sc_path_up);
  // Only a healthy path being switched away from may be aborted or retargeted mid-drain.
  assign pure_switch = (drain_target_q != path_sel_q) && active_up;

  always_comb begin
    state_d         = state_q;
    path_sel_d      = path_sel_q;
    drain_target_d  = drain_target_q;
    settle_d        = '0;
    tmo_d           = '0;
    drain_timeout_d = drain_timeout_q;
    unique case (state_q)
      PSW_INIT: begin
        if (active_up) state_d = PSW_ACTIVE;
      end
      PSW_ACTIVE: begin
        if (mode_select != path_sel_q) begin
          drain_target_d = mode_select;
          state_d        = PSW_DRAIN;
        end else if (!active_up) begin
          drain_target_d = path_sel_q;
          state_d        = PSW_DRAIN;
        end
      end
      PSW_DRAIN: begin
        tmo_d = (tmo_q == TMO_W'(DRAIN_TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
        if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) drain_timeout_d = 1'b1;
        if (pure_switch && (mode_select == path_sel_q)) begin
          state_d = PSW_ACTIVE;
        end else if (pure_switch && (mode_select != drain_target_q)) begin
          drain_target_d = mode_select;
        end else if ((wr_ost == '0) && (rd_ost == '0)) begin
          state_d    = PSW_SWITCH;
          path_sel_d = drain_target_q;
        end
        if (state_d != PSW_DRAIN) tmo_d = '0;
      end
      PSW_SWITCH: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = PSW_INIT;
        else                                       settle_d = settle_q + SET_W'(1);
      end
      default: state_d = PSW_INIT;
    endcase
  end

  always_comb begin
    path_sel      = path_sel_q;
    aw_gate       = (state_q == PSW_ACTIVE) && (wr_ost < OST_W'(MAX_OST));
    ar_gate       = (state_q == PSW_ACTIVE) && (rd_ost < OST_W'(MAX_OST));
    rtl_ready     = (state_q == PSW_ACTIVE) && (path_sel_q == PATH_RTL);
    systemc_ready = (state_q == PSW_ACTIVE) && (path_sel_q == PATH_SC);
    ost_err       = wr_err | rd_err;
    drain_timeout = drain_timeout_q;
  end

endmodule

// File: tb/tb_openddr_path_switch_ctrl.sv
// Directed bench for openddr_path_switch_ctrl: reset, switching, saturation, abort, timeout, path drop.
module tb_openddr_path_switch_ctrl;
  import openddr_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst, mode_select, aw_hs, ar_hs, b_hs, r_last_hs;
  logic       rtl_path_up, sc_path_up;
  logic       path_sel, aw_gate, ar_gate, rtl_ready, systemc_ready;
  logic [4:0] wr_ost, rd_ost;
  logic       ost_err, drain_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  openddr_path_switch_ctrl dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .mode_select   (mode_select),
    .aw_hs         (aw_hs),
    .ar_hs         (ar_hs),
    .b_hs          (b_hs),
    .r_last_hs     (r_last_hs),
    .rtl_path_up   (rtl_path_up),
    .sc_path_up    (sc_path_up),
    .path_sel      (path_sel),
    .aw_gate       (aw_gate),
    .ar_gate       (ar_gate),
    .rtl_ready     (rtl_ready),
    .systemc_ready (systemc_ready),
    .wr_ost        (wr_ost),
    .rd_ost        (rd_ost),
    .ost_err       (ost_err),
    .drain_timeout (drain_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_path_sel"}, 32'(path_sel), 32'd0);
    check({tag, "_aw_gate"},  32'(aw_gate), 32'd0);
    check({tag, "_ar_gate"},  32'(ar_gate), 32'd0);
    check({tag, "_rtl_rdy"},  32'(rtl_ready), 32'd0);
    check({tag, "_sc_rdy"},   32'(systemc_ready), 32'd0);
    check({tag, "_wr_ost"},   32'(wr_ost), 32'd0);
    check({tag, "_rd_ost"},   32'(rd_ost), 32'd0);
    check({tag, "_ost_err"},  32'(ost_err), 32'd0);
    check({tag, "_dr_tmo"},   32'(drain_timeout), 32'd0);
  endtask

  initial begin
    sys_rst = 1'b1; mode_select = 1'b0; aw_hs = 1'b0; ar_hs = 1'b0;
    b_hs = 1'b0; r_last_hs = 1'b0; rtl_path_up = 1'b1; sc_path_up = 1'b0;

    // 1. reset, then ACTIVE on RTL one cycle after release
    step(3);
    check_reset_outputs("rst");
    sys_rst = 1'b0;
    step();
    check("t1_rtl_ready", 32'(rtl_ready), 32'd1);
    check("t1_aw_gate",   32'(aw_gate), 32'd1);
    check("t1_ar_gate",   32'(ar_gate), 32'd1);
    check("t1_sc_ready",  32'(systemc_ready), 32'd0);

    // 2. switch to SystemC with 3 writes in flight
    aw_hs = 1'b1;
    step(3);
    aw_hs = 1'b0;
    check("t2_wr_ost3", 32'(wr_ost), 32'd3);
    mode_select = 1'b1;
    step();
    check("t2_drain", st(), 32'(PSW_DRAIN));
    check("t2_aw_gate_drop", 32'(aw_gate), 32'd0);
    check("t2_ar_gate_drop", 32'(ar_gate), 32'd0);
    check("t2_rtl_ready_drop", 32'(rtl_ready), 32'd0);
    step(3);
    check("t2_hold_drain", st(), 32'(PSW_DRAIN));
    check("t2_hold_path", 32'(path_sel), 32'd0);
    b_hs = 1'b1;
    step(3);
    b_hs = 1'b0;
    check("t2_wr_ost0", 32'(wr_ost), 32'd0);
    check("t2_path_pre", 32'(path_sel), 32'd0);
    step();
    check("t2_switch", st(), 32'(PSW_SWITCH));
    check("t2_path_sc", 32'(path_sel), 32'd1);
    step(3);
    check("t2_settle", st(), 32'(PSW_SWITCH));
    check("t2_sc_ready_settle", 32'(systemc_ready), 32'd0);
    step();
    check("t2_init", st(), 32'(PSW_INIT));
    step(2);
    check("t2_wait_up", 32'(systemc_ready), 32'd0);
    sc_path_up = 1'b1;
    step();
    check("t2_sc_ready", 32'(systemc_ready), 32'd1);
    check("t2_rtl_ready_off", 32'(rtl_ready), 32'd0);
    check("t2_aw_gate_sc", 32'(aw_gate), 32'd1);

    // zero-outstanding switch back: 1 + 1 + 4 + 1 = 7 cycles
    mode_select = 1'b0;
    step(6);
    check("lat_not_yet", 32'(rtl_ready), 32'd0);
    step();
    check("lat_rtl_ready", 32'(rtl_ready), 32'd1);
    check("lat_path_rtl", 32'(path_sel), 32'd0);

    // 3. read-side saturation
    ar_hs = 1'b1;
    step(16);
    check("t3_rd_ost16", 32'(rd_ost), 32'd16);
    check("t3_ar_gate", 32'(ar_gate), 32'd0);
    check("t3_aw_gate", 32'(aw_gate), 32'd1);
    check("t3_no_err", 32'(ost_err), 32'd0);
    step();
    ar_hs = 1'b0;
    check("t3_rd_sat", 32'(rd_ost), 32'd16);
    check("t3_ovf_err", 32'(ost_err), 32'd1);

    sys_rst = 1'b1;
    step();
    check("t3_rst_err", 32'(ost_err), 32'd0);
    check("t3_rst_rd", 32'(rd_ost), 32'd0);
    sys_rst = 1'b0;
    step();

    // 4. simultaneous inc/dec, then underflow
    aw_hs = 1'b1;
    step(2);
    b_hs = 1'b1;
    step();
    check("t4_same_cycle", 32'(wr_ost), 32'd2);
    check("t4_same_err", 32'(ost_err), 32'd0);
    aw_hs = 1'b0;
    step(2);
    check("t4_wr_zero", 32'(wr_ost), 32'd0);
    check("t4_no_err", 32'(ost_err), 32'd0);
    step();
    b_hs = 1'b0;
    check("t4_udf_hold", 32'(wr_ost), 32'd0);
    check("t4_udf_err", 32'(ost_err), 32'd1);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    step();
    check("t4_active", 32'(rtl_ready), 32'd1);

    // 5. abort mid-drain; handshake on the sampling cycle still counts
    aw_hs = 1'b1; mode_select = 1'b1;
    step();
    aw_hs = 1'b0;
    check("t5_counted", 32'(wr_ost), 32'd1);
    check("t5_drain", st(), 32'(PSW_DRAIN));
    step(2);
    check("t5_path_hold", 32'(path_sel), 32'd0);
    mode_select = 1'b0;
    step();
    check("t5_abort", 32'(rtl_ready), 32'd1);
    check("t5_abort_path", 32'(path_sel), 32'd0);
    check("t5_abort_wr", 32'(wr_ost), 32'd1);

    // drain timeout after 1024 DRAIN cycles
    mode_select = 1'b1;
    step();
    check("t5_drain2", st(), 32'(PSW_DRAIN));
    step(1023);
    check("t5_tmo_early", 32'(drain_timeout), 32'd0);
    step();
    check("t5_tmo", 32'(drain_timeout), 32'd1);
    check("t5_tmo_state", st(), 32'(PSW_DRAIN));
    check("t5_tmo_path", 32'(path_sel), 32'd0);

    // 6b. reset mid-DRAIN
    sys_rst = 1'b1; mode_select = 1'b0;
    step();
    check_reset_outputs("t6_rst");
    check("t6_rst_state", st(), 32'(PSW_INIT));
    sys_rst = 1'b0;
    step();
    check("t6_active", 32'(rtl_ready), 32'd1);

    // 6. active path drops: drain, switch to same path, wait for up
    rtl_path_up = 1'b0;
    step();
    check("t6_drain", st(), 32'(PSW_DRAIN));
    check("t6_gate", 32'(aw_gate), 32'd0);
    step();
    check("t6_switch", st(), 32'(PSW_SWITCH));
    check("t6_path", 32'(path_sel), 32'd0);
    step(4);
    check("t6_init", st(), 32'(PSW_INIT));
    step(2);
    check("t6_wait", 32'(rtl_ready), 32'd0);
    rtl_path_up = 1'b1;
    step();
    check("t6_up", 32'(rtl_ready), 32'd1);
    check("t6_path_end", 32'(path_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
